xcorr_lag_search: RTL and testbench

//  Multi-channel cross-correlator for the phased-array mic path.
//  - Correlates one reference buffer (RAM A) against NCH channel buffers (RAM B, banked by b_ch)

---
 rtl/xcorr_pkg.sv | 48 ++++
 rtl/xcorr_mac.sv | 68 ++++++
 rtl/xcorr_lag_search.sv | 208 ++++++++++++++++++++
 tb/tb_xcorr_lag_search.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcorr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xcorr_pkg
//  Description : Shared types and helpers for the lag-search cross-correlator:
//                FSM state encoding, lag-range helpers and the
//                shift-and-saturate function that maps an accumulator to
//                the stored result width.
//  Revision    : 1.0 - initial release
// ============================================================================
package xcorr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_PEAK  = 3'd5
  } state_t;

  // Largest lag magnitude representable in a signed lag field of lag_w bits.
  function automatic int max_lag_of(input int lag_w);
    return (1 << (lag_w - 1)) - 1;
  endfunction

  // Number of lags in -MAX_LAG..+MAX_LAG.
  function automatic int nlag_of(input int lag_w);
    return 2 * max_lag_of(lag_w) + 1;
  endfunction

  // Arithmetic right shift followed by clamping to a signed out_w-bit range.
  // Works at 64 bits; callers truncate to out_w.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int                 shift,
                                                   input int                 out_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage : xcorr_pkg
`default_nettype wire

// File: rtl/xcorr_mac.sv
`default_nettype none
// ============================================================================
//  Module      : xcorr_mac
//  Description : Registered signed multiply-accumulate. The issue strobe is
//                delayed by RD_LAT so it lines up with the RAM read data;
//                the product is registered, then sign-extended and summed.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                i_clear         - zero the accumulator
//                i_valid         - address pair issued this cycle
//                i_a, i_b        - RAM read data (signed)
//                o_acc           - running sum
//  Revision    : 1.0 - initial release
// ============================================================================
module xcorr_mac
  import xcorr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 25,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam int c_prod_w = 2 * DATA_W;

  logic [RD_LAT-1:0]          r_vld_sr;
  logic                       r_prod_vld;
  logic signed [c_prod_w-1:0] r_prod;
  logic signed [ACC_W-1:0]    r_acc;

  // Top bit of r_vld_sr is high in the cycle the matching read data arrives.
  generate
    if (RD_LAT == 1) begin : g_vld_single
      always_ff @(posedge clk) begin
        if (reset) r_vld_sr <= '0;
        else       r_vld_sr <= i_valid;
      end
    end else begin : g_vld_chain
      always_ff @(posedge clk) begin
        if (reset) r_vld_sr <= '0;
        else       r_vld_sr <= {r_vld_sr[RD_LAT-2:0], i_valid};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_prod     <= c_prod_w'(i_a) * c_prod_w'(i_b);
      r_prod_vld <= r_vld_sr[RD_LAT-1];
      if (i_clear)         r_acc <= '0;
      else if (r_prod_vld) r_acc <= r_acc + ACC_W'(r_prod);
    end
  end

  assign o_acc = r_acc;

endmodule : xcorr_mac
`default_nettype wire

// File: rtl/xcorr_lag_search.sv
`default_nettype none
// ============================================================================
//  Module      : xcorr_lag_search
//  Description : Correlates reference RAM A against NCH banked channel
//                buffers in RAM B over lags -MAX_LAG..+MAX_LAG, writes every
//                scaled/saturated lag result and reports each channel's peak.
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                i_start / o_busy / o_valid - run handshake
//                o_a_addr, i_a_data     - reference RAM read port
//                o_b_ch, o_b_addr, i_b_data - channel RAM read port
//                o_s_addr, o_s_data, o_s_wren - result RAM write port
//                o_peak_we, o_peak_ch, o_peak_lag, o_peak_val - peak report
//  Revision    : 1.0 - initial release
// ============================================================================
module xcorr_lag_search
  import xcorr_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int LAG_W  = 8,
  parameter int NCH    = 4,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 8,
  parameter int RD_LAT = 1,
  parameter int ACC_W  = 2 * DATA_W + ADDR_W,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [ADDR_W-1:0]      o_a_addr,
  input  logic [DATA_W-1:0]      i_a_data,
  output logic [CH_W-1:0]        o_b_ch,
  output logic [ADDR_W-1:0]      o_b_addr,
  input  logic [DATA_W-1:0]      i_b_data,
  output logic [CH_W+LAG_W-1:0]  o_s_addr,
  output logic [OUT_W-1:0]       o_s_data,
  output logic                   o_s_wren,
  output logic                   o_peak_we,
  output logic [CH_W-1:0]        o_peak_ch,
  output logic [LAG_W-1:0]       o_peak_lag,
  output logic [OUT_W-1:0]       o_peak_val
);

  localparam int                c_dcnt_w     = $clog2(RD_LAT + 3);
  localparam logic [LAG_W-1:0]  c_max_lag    = LAG_W'(max_lag_of(LAG_W));
  localparam logic [LAG_W-1:0]  c_last_kidx  = LAG_W'(nlag_of(LAG_W) - 1);
  localparam logic [CH_W-1:0]   c_last_ch    = CH_W'(NCH - 1);
  localparam logic [c_dcnt_w-1:0] c_drain_last = c_dcnt_w'(RD_LAT + 1);

  state_t                    r_state;
  logic [CH_W-1:0]           r_ch;
  logic [LAG_W-1:0]          r_kidx;       // k + MAX_LAG
  logic [ADDR_W-1:0]         r_a_addr;     // n
  logic [ADDR_W-1:0]         r_b_addr;     // n + k
  logic [c_dcnt_w-1:0]       r_dcnt;
  logic                      r_busy;
  logic                      r_valid;
  logic [CH_W+LAG_W-1:0]     r_s_addr;
  logic signed [OUT_W-1:0]   r_s_data;
  logic                      r_s_wren;
  logic                      r_peak_we;
  logic [CH_W-1:0]           r_peak_ch;
  logic [LAG_W-1:0]          r_peak_lag;
  logic signed [OUT_W-1:0]   r_peak_val;
  logic signed [ACC_W-1:0]   r_best_acc;
  logic [LAG_W-1:0]          r_best_kidx;

  logic signed [ACC_W-1:0]   w_acc;
  logic                      w_k_neg;
  logic [LAG_W-1:0]          w_kmag;
  logic                      w_last_n;
  logic signed [OUT_W-1:0]   w_acc_sat;
  logic signed [OUT_W-1:0]   w_best_sat;

  xcorr_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .RD_LAT (RD_LAT)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state == ST_CLEAR),
    .i_valid (r_state == ST_RUN),
    .i_a     (i_a_data),
    .i_b     (i_b_data),
    .o_acc   (w_acc)
  );

  assign w_k_neg    = (r_kidx < c_max_lag);
  assign w_kmag     = w_k_neg ? (c_max_lag - r_kidx) : (r_kidx - c_max_lag);
  // The window ends when either index reaches the top sample, which is
  // exactly n = min(NSAMP-1, NSAMP-1-k).
  assign w_last_n   = (&r_a_addr) | (&r_b_addr);
  assign w_acc_sat  = OUT_W'(sat_shift(64'(w_acc), SHIFT, OUT_W));
  assign w_best_sat = OUT_W'(sat_shift(64'(r_best_acc), SHIFT, OUT_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_kidx      <= '0;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_dcnt      <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_s_addr    <= '0;
      r_s_data    <= '0;
      r_s_wren    <= 1'b0;
      r_peak_we   <= 1'b0;
      r_peak_ch   <= '0;
      r_peak_lag  <= '0;
      r_peak_val  <= '0;
      r_best_acc  <= '0;
      r_best_kidx <= '0;
    end else begin
      r_s_wren  <= 1'b0;
      r_peak_we <= 1'b0;
      r_valid   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_ch    <= '0;
            r_kidx  <= '0;
          end
        end
        ST_CLEAR: begin
          // Start of window: one index is 0, the other is |k|.
          r_a_addr <= w_k_neg ? ADDR_W'(w_kmag) : '0;
          r_b_addr <= w_k_neg ? '0 : ADDR_W'(w_kmag);
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          if (w_last_n) begin
            r_state <= ST_DRAIN;
            r_dcnt  <= '0;
          end else begin
            r_a_addr <= r_a_addr + 1'b1;
            r_b_addr <= r_b_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The last DRAIN cycle is the first one where w_acc is final.
          if (r_dcnt == c_drain_last) begin
            r_state  <= ST_WRITE;
            r_s_wren <= 1'b1;
            r_s_addr <= {r_ch, r_kidx};
            r_s_data <= w_acc_sat;
            if ((r_kidx == '0) || (w_acc > r_best_acc)) begin
              r_best_acc  <= w_acc;
              r_best_kidx <= r_kidx;
            end
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        ST_WRITE: begin
          if (r_kidx == c_last_kidx) begin
            r_state    <= ST_PEAK;
            r_peak_we  <= 1'b1;
            r_peak_ch  <= r_ch;
            r_peak_lag <= r_best_kidx - c_max_lag;
            r_peak_val <= w_best_sat;
            // valid coincides with the final PEAK cycle, so a start seen
            // alongside it is never accepted.
            if (r_ch == c_last_ch) begin
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_kidx  <= r_kidx + 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_PEAK: begin
          if (r_ch == c_last_ch) begin
            r_state <= ST_IDLE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_kidx  <= '0;
            r_state <= ST_CLEAR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_valid    = r_valid;
  assign o_a_addr   = r_a_addr;
  assign o_b_ch     = r_ch;
  assign o_b_addr   = r_b_addr;
  assign o_s_addr   = r_s_addr;
  assign o_s_data   = r_s_data;
  assign o_s_wren   = r_s_wren;
  assign o_peak_we  = r_peak_we;
  assign o_peak_ch  = r_peak_ch;
  assign o_peak_lag = r_peak_lag;
  assign o_peak_val = r_peak_val;

endmodule : xcorr_lag_search
`default_nettype wire

// File: tb/tb_xcorr_lag_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xcorr_lag_search
//  Description : Self-checking bench for xcorr_lag_search on a reduced
//                geometry (16 samples, lags -7..+7, 4 channels). RAMs are
//                modelled behaviourally; results are compared against a
//                direct-sum reference model and hand-derived peak values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xcorr_lag_search;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int LAG_W   = 4;
  localparam int NCH     = 4;
  localparam int OUT_W   = 8;
  localparam int SHIFT   = 8;
  localparam int RD_LAT  = 1;
  localparam int CH_W    = 2;
  localparam int NSAMP   = 16;
  localparam int MAX_LAG = 7;
  localparam int NLAG    = 15;
  localparam int TMO     = 20000;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  busy;
  logic                  valid;
  logic [ADDR_W-1:0]     a_addr;
  logic [DATA_W-1:0]     a_q;
  logic [CH_W-1:0]       b_ch;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W-1:0]     b_q;
  logic [CH_W+LAG_W-1:0] s_addr;
  logic [OUT_W-1:0]      s_data;
  logic                  s_wren;
  logic                  peak_we;
  logic [CH_W-1:0]       peak_ch;
  logic [LAG_W-1:0]      peak_lag;
  logic [OUT_W-1:0]      peak_val;

  xcorr_lag_search #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LAG_W (LAG_W), .NCH (NCH),
    .OUT_W  (OUT_W),  .SHIFT  (SHIFT),  .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .o_busy     (busy),
    .o_valid    (valid),
    .o_a_addr   (a_addr),
    .i_a_data   (a_q),
    .o_b_ch     (b_ch),
    .o_b_addr   (b_addr),
    .i_b_data   (b_q),
    .o_s_addr   (s_addr),
    .o_s_data   (s_data),
    .o_s_wren   (s_wren),
    .o_peak_we  (peak_we),
    .o_peak_ch  (peak_ch),
    .o_peak_lag (peak_lag),
    .o_peak_val (peak_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memories and one-cycle synchronous read ports.
  int mem_a [NSAMP];
  int mem_b [NCH][NSAMP];

  always @(posedge clk) begin
    a_q <= DATA_W'(mem_a[a_addr]);
    b_q <= DATA_W'(mem_b[b_ch][b_addr]);
  end

  // Capture of DUT writes and reports.
  int got [NCH][NLAG];
  int pk_lag [NCH];
  int pk_val [NCH];
  int wr_cnt, pk_cnt, valid_cnt, bad_addr;
  bit saw_ch1;
  int mon_ch, mon_k;

  always @(negedge clk) begin
    if (s_wren) begin
      wr_cnt++;
      mon_ch = int'(s_addr[CH_W+LAG_W-1:LAG_W]);
      mon_k  = int'(s_addr[LAG_W-1:0]);
      if (mon_k >= NLAG) bad_addr++;
      else begin
        got[mon_ch][mon_k] = int'($signed(s_data));
        if (mon_ch == 1) saw_ch1 = 1'b1;
      end
    end
    if (peak_we) begin
      pk_cnt++;
      pk_lag[peak_ch] = int'($signed(peak_lag));
      pk_val[peak_ch] = int'($signed(peak_val));
    end
    if (valid) valid_cnt++;
  end

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Reference model: direct sum over the valid overlap of every lag.
  int exp_s [NCH][NLAG];
  int exp_pl [NCH];
  int exp_pv [NCH];

  function automatic int sat_out(input longint acc);
    longint v;
    longint hi;
    v  = acc >>> SHIFT;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    if (v > hi)      return int'(hi);
    if (v < -hi - 1) return int'(-hi - 1);
    return int'(v);
  endfunction

  function automatic void model();
    longint acc;
    longint best;
    for (int c = 0; c < NCH; c++) begin
      best = 0;
      for (int ki = 0; ki < NLAG; ki++) begin
        acc = 0;
        for (int n = 0; n < NSAMP; n++)
          if (n + ki - MAX_LAG >= 0 && n + ki - MAX_LAG < NSAMP)
            acc += longint'(mem_a[n]) * longint'(mem_b[c][n + ki - MAX_LAG]);
        exp_s[c][ki] = sat_out(acc);
        if (ki == 0 || acc > best) begin
          best      = acc;
          exp_pl[c] = ki - MAX_LAG;
          exp_pv[c] = sat_out(acc);
        end
      end
    end
  endfunction

  task automatic clear_cap();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NLAG; k++) got[c][k] = 9999;
      pk_lag[c] = 9999;
      pk_val[c] = 9999;
    end
    wr_cnt = 0; pk_cnt = 0; valid_cnt = 0; bad_addr = 0; saw_ch1 = 1'b0;
  endtask

  task automatic fill_zero();
    for (int n = 0; n < NSAMP; n++) begin
      mem_a[n] = 0;
      for (int c = 0; c < NCH; c++) mem_b[c][n] = 0;
    end
  endtask

  task automatic fill_rand();
    for (int n = 0; n < NSAMP; n++) begin
      mem_a[n] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < NCH; c++) mem_b[c][n] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // One complete run; optionally re-pulses start mid-run and alongside valid.
  task automatic do_run(input string nm, input bit mid_start, input bit at_valid);
    bit done;
    clear_cap();
    @(posedge clk); #1 start = 1'b1;
    done = 1'b0;
    for (int i = 0; i < TMO && !done; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mid_start && i == 50) begin
        chk({nm, "_busy_mid"}, busy, 1);
        start = 1'b1;
      end
      if (valid) begin
        done = 1'b1;
        if (at_valid) start = 1'b1;
      end
    end
    @(posedge clk); #1 start = 1'b0;
    chk({nm, "_done_in_time"}, done, 1);
    repeat (30) @(posedge clk);
    #1;
    chk({nm, "_valid_count"}, valid_cnt, 1);
    chk({nm, "_write_count"}, wr_cnt, NCH * NLAG);
    chk({nm, "_peak_count"}, pk_cnt, NCH);
    chk({nm, "_bad_addr"}, bad_addr, 0);
    chk({nm, "_busy_after"}, busy, 0);
  endtask

  task automatic check_all(input string nm);
    model();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NLAG; k++)
        chk($sformatf("%s_s_ch%0d_lag%0d", nm, c, k - MAX_LAG), got[c][k], exp_s[c][k]);
      chk($sformatf("%s_peaklag_ch%0d", nm, c), pk_lag[c], exp_pl[c]);
      chk($sformatf("%s_peakval_ch%0d", nm, c), pk_val[c], exp_pv[c]);
    end
  endtask

  typedef struct {
    int a_i; int a_v; int ch; int b_i; int b_v; int exp_lag; int exp_val;
  } vec_t;

  vec_t vecs [7];
  int   wc;

  initial begin
    // Impulse vectors with hand-derived peaks for the stimulated channel.
    vecs[0] = '{a_i: 5,  a_v: 64,   ch: 0, b_i: 8,  b_v: 64,   exp_lag: 3,  exp_val: 16};
    vecs[1] = '{a_i: 5,  a_v: 64,   ch: 1, b_i: 2,  b_v: 64,   exp_lag: -3, exp_val: 16};
    vecs[2] = '{a_i: 0,  a_v: 100,  ch: 2, b_i: 7,  b_v: -100, exp_lag: -7, exp_val: 0};
    vecs[3] = '{a_i: 15, a_v: 127,  ch: 3, b_i: 8,  b_v: 127,  exp_lag: -7, exp_val: 63};
    vecs[4] = '{a_i: 5,  a_v: 127,  ch: 0, b_i: 5,  b_v: 127,  exp_lag: 0,  exp_val: 63};
    vecs[5] = '{a_i: 9,  a_v: -128, ch: 1, b_i: 2,  b_v: -128, exp_lag: -7, exp_val: 64};
    vecs[6] = '{a_i: 0,  a_v: 127,  ch: 2, b_i: 15, b_v: 127,  exp_lag: -7, exp_val: 0};

    reset = 1'b1;
    start = 1'b0;
    fill_zero();
    clear_cap();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_s_wren", s_wren, 0);
    chk("rst_peak_we", peak_we, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_peak_lag", peak_lag, 0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill_zero();
      mem_a[vecs[v].a_i]            = vecs[v].a_v;
      mem_b[vecs[v].ch][vecs[v].b_i] = vecs[v].b_v;
      do_run($sformatf("vec%0d", v), 1'b0, 1'b0);
      chk($sformatf("vec%0d_tbl_lag", v), pk_lag[vecs[v].ch], vecs[v].exp_lag);
      chk($sformatf("vec%0d_tbl_val", v), pk_val[vecs[v].ch], vecs[v].exp_val);
      check_all($sformatf("vec%0d", v));
    end

    // Saturation in both directions.
    fill_zero();
    for (int n = 0; n < NSAMP; n++) begin
      mem_a[n] = 127; mem_b[2][n] = 127; mem_b[3][n] = -128;
    end
    do_run("sat", 1'b0, 1'b0);
    chk("sat_pos_lag0", got[2][MAX_LAG], 127);
    chk("sat_neg_lagmin", got[3][0], -128);
    chk("sat_neg_lagmax", got[3][NLAG-1], -128);
    check_all("sat");

    // Edge lags: overlap of 9 samples at +/-7, 16 at 0.
    fill_zero();
    for (int n = 0; n < NSAMP; n++) begin
      mem_a[n] = 16; mem_b[0][n] = 16;
    end
    do_run("edge", 1'b0, 1'b0);
    chk("edge_lagmin", got[0][0], 9);
    chk("edge_lagmax", got[0][NLAG-1], 9);
    chk("edge_lag0", got[0][MAX_LAG], 16);
    chk("edge_peaklag", pk_lag[0], 0);
    check_all("edge");

    for (int r = 0; r < 2; r++) begin
      fill_rand();
      do_run($sformatf("rand%0d", r), 1'b0, 1'b0);
      check_all($sformatf("rand%0d", r));
    end

    // Start re-pulsed mid-run and in the valid cycle must be ignored.
    fill_rand();
    do_run("hs", 1'b1, 1'b1);
    check_all("hs");

    // Reset during channel 1, then a clean rerun of the first impulse.
    fill_zero();
    mem_a[5] = 64; mem_b[0][8] = 64;
    clear_cap();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < TMO && !saw_ch1; i++) @(posedge clk);
    chk("rst_mid_reached_ch1", saw_ch1, 1);
    repeat ($urandom_range(1, 30)) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_s_wren", s_wren, 0);
    chk("rst_mid_valid", valid, 0);
    reset = 1'b0;
    wc = wr_cnt;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_mid_no_valid", valid_cnt, 0);
    chk("rst_mid_no_writes", wr_cnt, wc);
    do_run("rerun", 1'b0, 1'b0);
    chk("rerun_lag", pk_lag[0], 3);
    chk("rerun_val", pk_val[0], 16);
    check_all("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_xcorr_lag_search
`default_nettype wire
